// File: rtl/sdram_a_ref_if.sv
// Refresh-requester bus between the SDRAM auto-refresh block and its arbiter/command mux.
// The slave side is the refresh block; the master side is the arbiter (or a bench).
interface sdram_a_ref_if;
  logic        init_end;
  logic        aref_en;
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        aref_end;

  modport slave (
    input  init_end,
    input  aref_en,
    output aref_req,
    output aref_cmd,
    output aref_ba,
    output aref_addr,
    output aref_end
  );

  modport master (
    output init_end,
    output aref_en,
    input  aref_req,
    input  aref_cmd,
    input  aref_ba,
    input  aref_addr,
    input  aref_end
  );
endinterface

// File: rtl/sdram_a_ref.sv
// SDRAM auto-refresh controller: raises a periodic refresh request and, once granted,
// issues PRECHARGE-all followed by two AUTO_REFRESH commands with the required NOP gaps.
module sdram_a_ref #(
  parameter int CNT_REF_MAX = 749,
  parameter int TRP_CLK     = 2,
  parameter int TRC_CLK     = 7
) (
  input logic         sys_clk,
  input logic         sys_rst,
  sdram_a_ref_if.slave bus
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int REF_W   = $clog2(CNT_REF_MAX + 1);
  localparam int CYC_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCHA,
    S_TRP,
    S_AREF,
    S_TRF,
    S_END
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [REF_W-1:0]   cnt_ref;
  logic [CYC_W-1:0]   cnt_cyc;
  logic [1:0]         aref_cnt;
  logic               ref_due;
  logic               grant;
  logic               trp_done;
  logic               trc_done;

  assign ref_due  = (cnt_ref == REF_W'(CNT_REF_MAX));
  assign grant    = (state == S_IDLE) && bus.aref_en && bus.init_end;
  assign trp_done = (cnt_cyc == CYC_W'(TRP_CLK - 1));
  assign trc_done = (cnt_cyc == CYC_W'(TRC_CLK - 1));

  // Interval counter free-runs once init is done; a grant never disturbs it.
  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_ref <= '0;
    end else if (!bus.init_end) begin
      cnt_ref <= '0;
    end else if (ref_due) begin
      cnt_ref <= '0;
    end else begin
      cnt_ref <= cnt_ref + REF_W'(1);
    end
  end

  // A new interval elapsing wins over a same-cycle grant; requests never queue.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.aref_req <= 1'b0;
    end else if (ref_due) begin
      bus.aref_req <= 1'b1;
    end else if (grant) begin
      bus.aref_req <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (grant) state_next = S_PCHA;
      S_PCHA: state_next = S_TRP;
      S_TRP:  if (trp_done) state_next = S_AREF;
      S_AREF: state_next = S_TRF;
      S_TRF: begin
        if (trc_done) begin
          state_next = (aref_cnt == 2'd1) ? S_AREF : S_END;
        end
      end
      S_END:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change, so TRP and TRF each time from zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_cyc <= '0;
    end else if (state != state_next) begin
      cnt_cyc <= '0;
    end else if (state == S_TRP || state == S_TRF) begin
      cnt_cyc <= cnt_cyc + CYC_W'(1);
    end else begin
      cnt_cyc <= '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      aref_cnt <= 2'd0;
    end else if (state == S_AREF) begin
      aref_cnt <= aref_cnt + 2'd1;
    end else if (state == S_END) begin
      aref_cnt <= 2'd0;
    end
  end

  // Commands decode straight from the state register, so reset forces NOP immediately.
  always_comb begin
    bus.aref_cmd = CMD_NOP;
    case (state)
      S_PCHA:  bus.aref_cmd = CMD_PRE;
      S_AREF:  bus.aref_cmd = CMD_AREF;
      default: bus.aref_cmd = CMD_NOP;
    endcase
  end

  assign bus.aref_end  = (state == S_END);
  assign bus.aref_ba   = 2'b11;
  assign bus.aref_addr = 13'h1FFF;

endmodule

// File: tb/tb_sdram_a_ref.sv
// Self-checking bench for sdram_a_ref: directed scenarios plus randomized grants, init drops
// and resets, compared every cycle against a timeline-based reference model.
module tb_sdram_a_ref;

  localparam int CNT_REF_MAX = 749;
  localparam int TRP_CLK     = 2;
  localparam int TRC_CLK     = 7;
  localparam int PERIOD      = CNT_REF_MAX + 1;

  // Offsets from the grant edge at which each command appears.
  localparam int OFF_PRE   = 1;
  localparam int OFF_AREF1 = OFF_PRE + 1 + TRP_CLK;
  localparam int OFF_AREF2 = OFF_AREF1 + 1 + TRC_CLK;
  localparam int OFF_END   = OFF_AREF2 + 1 + TRC_CLK;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_end_seen = 0;

  int   m_phase;
  bit   m_req;
  int   m_off;

  sdram_a_ref_if bus ();

  sdram_a_ref #(
    .CNT_REF_MAX (CNT_REF_MAX),
    .TRP_CLK     (TRP_CLK),
    .TRC_CLK     (TRC_CLK)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_cmd(input int off);
    if (off == OFF_PRE) return 4'b0010;
    if (off == OFF_AREF1 || off == OFF_AREF2) return 4'b0001;
    return 4'b0111;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_req   = 1'b0;
    m_off   = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit granted;
    granted = (m_off == 0) && bus.aref_en && bus.init_end;
    if (m_phase == CNT_REF_MAX) m_req = 1'b1;
    else if (granted)           m_req = 1'b0;
    m_phase = bus.init_end ? (m_phase + 1) % PERIOD : 0;
    if (granted)                m_off = 1;
    else if (m_off == OFF_END)  m_off = 0;
    else if (m_off != 0)        m_off = m_off + 1;
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_req"},  {31'd0, bus.aref_req}, {31'd0, m_req});
    chk({pfx, "_cmd"},  {28'd0, bus.aref_cmd}, {28'd0, exp_cmd(m_off)});
    chk({pfx, "_end"},  {31'd0, bus.aref_end}, {31'd0, (m_off == OFF_END)});
    chk({pfx, "_ba"},   {30'd0, bus.aref_ba},  32'd3);
    chk({pfx, "_addr"}, {19'd0, bus.aref_addr}, 32'h1FFF);
  endtask

  // One cycle: check outputs mid-cycle, drive this cycle's inputs, advance the model.
  task automatic tick(input logic en, input logic ie);
    @(negedge sys_clk);
    compare_all("cyc");
    if (bus.aref_end) n_end_seen++;
    bus.aref_en   = en;
    bus.init_end  = ie;
    model_step();
  endtask

  // Called just after a tick: asserts reset inside the current cycle and releases next cycle.
  task automatic pulse_reset();
    sys_rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge sys_clk);
    compare_all("rst_hold");
    bus.aref_en = 1'b0;
    sys_rst     = 1'b0;
    model_step();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_off != 0 && guard < 100) begin
      tick(1'b0, bus.init_end);
      guard++;
    end
  endtask

  initial begin
    int first;
    int ends0;
    sys_rst      = 1'b1;
    bus.aref_en  = 1'b0;
    bus.init_end = 1'b0;
    model_reset();
    #1;
    compare_all("por");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_step();

    // Init not finished: no request, NOP throughout, even with stray grants.
    for (int i = 0; i < 2000; i++) tick(($urandom_range(0, 15) == 0), 1'b0);

    // Init completes now: request first seen 750 cycles later and survives the next wrap.
    tick(1'b0, 1'b1);
    first = -1;
    for (int k = 1; k <= 1505; k++) begin
      tick(1'b0, 1'b1);
      if (first < 0 && bus.aref_req) first = k;
      if (k == 1502) chk("req_held_after_wrap", {31'd0, bus.aref_req}, 32'd1);
    end
    chk("req_first_after_init", first, PERIOD);

    // Single-cycle grant: exactly one full sequence.
    ends0 = n_end_seen;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("req_cleared_by_grant", {31'd0, bus.aref_req}, 32'd0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
    chk("single_grant_ends", n_end_seen - ends0, 1);

    // Grant held for 40 cycles: second sequence from the IDLE return, no third.
    wait_idle();
    ends0 = n_end_seen;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
    chk("held_grant_ends", n_end_seen - ends0, 2);

    // Reset during the first TRF gap: abort, no end pulse, full interval before next request.
    wait_idle();
    ends0 = n_end_seen;
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) tick(1'b0, 1'b1);
    pulse_reset();
    first = -1;
    for (int k = 1; k <= 760; k++) begin
      tick(1'b0, 1'b1);
      if (first < 0 && bus.aref_req) first = k;
    end
    chk("req_first_after_reset", first, PERIOD);
    chk("no_end_after_abort", n_end_seen - ends0, 0);

    // Randomized grants, occasional init drops and resets.
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 299) != 0));
      if ($urandom_range(0, 1499) == 0) pulse_reset();
    end

    // Arbiter that grants whenever a request is pending.
    for (int i = 0; i < 2000; i++) tick(m_req, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
